// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press/release/long/repeat
// pulses, a held level and a wrapping press counter. All outputs are registered.
module button_event_gen #(
    parameter int HOLD_CYCLES   = 500,
    parameter int REPEAT_CYCLES = 100,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pb_in,
    output logic             press_o,
    output logic             release_o,
    output logic             long_o,
    output logic             repeat_o,
    output logic             held_o,
    output logic [CNT_W-1:0] press_count
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int RW = $clog2(REPEAT_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;

    state_t           state, state_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic [RW-1:0]    rep_cnt, rep_n;
    logic             pb_q;
    logic             press_n, release_n, long_n, repeat_n, held_n;
    logic [CNT_W-1:0] count_n;
    logic             rise, fall;

    assign rise = pb_in & ~pb_q;
    assign fall = ~pb_in & pb_q;

    // pb_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            pb_q        <= 1'b1;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
            long_o      <= 1'b0;
            repeat_o    <= 1'b0;
            held_o      <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_n;
            hold_cnt    <= hold_n;
            rep_cnt     <= rep_n;
            pb_q        <= pb_in;
            press_o     <= press_n;
            release_o   <= release_n;
            long_o      <= long_n;
            repeat_o    <= repeat_n;
            held_o      <= held_n;
            press_count <= count_n;
        end
    end

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        rep_n     = rep_cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        count_n   = press_count;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = PRESS;
                    hold_n  = '0;
                    press_n = 1'b1;
                    count_n = press_count + CNT_W'(1);
                end
            end
            PRESS: begin
                // Release is checked first so it beats a coincident long threshold.
                if (fall) begin
                    state_n   = IDLE;
                    hold_n    = '0;
                    rep_n     = '0;
                    release_n = 1'b1;
                end else if (pb_in) begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        state_n = LONG;
                        hold_n  = '0;
                        rep_n   = '0;
                        long_n  = 1'b1;
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    state_n   = IDLE;
                    hold_n    = '0;
                    rep_n     = '0;
                    release_n = 1'b1;
                end else if (pb_in) begin
                    if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
                        rep_n    = '0;
                        repeat_n = 1'b1;
                    end else begin
                        rep_n = rep_cnt + RW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                hold_n  = '0;
                rep_n   = '0;
            end
        endcase
        held_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with HOLD=8, REPEAT=4, CNT_W=3.
module tb_button_event_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       pb_in;
    logic       press_o, release_o, long_o, repeat_o, held_o;
    logic [2:0] press_count;

    int errors = 0;
    int checks = 0;
    int n_press = 0;
    int n_rel = 0;

    button_event_gen #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .pb_in(pb_in),
        .press_o(press_o), .release_o(release_o), .long_o(long_o),
        .repeat_o(repeat_o), .held_o(held_o), .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Advance one edge, then compare {press,release,long,repeat,held,count}.
    task automatic tick_chk(input string tag, input logic p, input logic r,
                            input logic l, input logic rp, input logic h,
                            input logic [2:0] c);
        logic [7:0] obs, exp;
        @(posedge clk);
        #1;
        obs = {press_o, release_o, long_o, repeat_o, held_o, press_count};
        exp = {p, r, l, rp, h, c};
        if (press_o) n_press++;
        if (release_o) n_rel++;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset, then a 5-cycle press
        rst = 1'b1; pb_in = 1'b0;
        tick_chk("reset", 0, 0, 0, 0, 0, 3'd0);
        rst = 1'b0;
        tick_chk("idle", 0, 0, 0, 0, 0, 3'd0);
        pb_in = 1'b1;
        tick_chk("s1_press", 1, 0, 0, 0, 1, 3'd1);
        for (int i = 2; i <= 5; i++) tick_chk("s1_held", 0, 0, 0, 0, 1, 3'd1);
        pb_in = 1'b0;
        tick_chk("s1_release", 0, 1, 0, 0, 0, 3'd1);
        tick_chk("s1_idle", 0, 0, 0, 0, 0, 3'd1);

        // 2: 20-cycle hold: long at 9, repeats at 13 and 17
        pb_in = 1'b1;
        for (int i = 1; i <= 20; i++)
            tick_chk("s2_hold", i == 1, 0, i == 9, (i > 9) && ((i - 9) % 4 == 0), 1, 3'd2);
        pb_in = 1'b0;
        tick_chk("s2_release", 0, 1, 0, 0, 0, 3'd2);
        tick_chk("s2_idle", 0, 0, 0, 0, 0, 3'd2);

        // 3: release coincides with long threshold
        pb_in = 1'b1;
        tick_chk("s3_press", 1, 0, 0, 0, 1, 3'd3);
        for (int i = 2; i <= 8; i++) tick_chk("s3_held", 0, 0, 0, 0, 1, 3'd3);
        pb_in = 1'b0;
        tick_chk("s3_release_wins", 0, 1, 0, 0, 0, 3'd3);
        tick_chk("s3_idle", 0, 0, 0, 0, 0, 3'd3);

        // 4: reset while in LONG with the button held
        pb_in = 1'b1;
        tick_chk("s4_press", 1, 0, 0, 0, 1, 3'd4);
        for (int i = 2; i <= 8; i++) tick_chk("s4_held", 0, 0, 0, 0, 1, 3'd4);
        tick_chk("s4_long", 0, 0, 1, 0, 1, 3'd4);
        tick_chk("s4_inlong", 0, 0, 0, 0, 1, 3'd4);
        rst = 1'b1;
        tick_chk("s4_reset", 0, 0, 0, 0, 0, 3'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick_chk("s4_no_press", 0, 0, 0, 0, 0, 3'd0);
        pb_in = 1'b0;
        tick_chk("s4_drop", 0, 0, 0, 0, 0, 3'd0);
        pb_in = 1'b1;
        tick_chk("s4_repress", 1, 0, 0, 0, 1, 3'd1);
        pb_in = 1'b0;
        tick_chk("s4_release", 0, 1, 0, 0, 0, 3'd1);

        // 5: nine short presses from a fresh reset, count wraps 7 -> 0
        rst = 1'b1;
        tick_chk("s5_reset", 0, 0, 0, 0, 0, 3'd0);
        rst = 1'b0;
        tick_chk("s5_idle", 0, 0, 0, 0, 0, 3'd0);
        n_press = 0; n_rel = 0;
        for (int n = 1; n <= 9; n++) begin
            pb_in = 1'b1;
            tick_chk("s5_press", 1, 0, 0, 0, 1, 3'(n % 8));
            tick_chk("s5_held", 0, 0, 0, 0, 1, 3'(n % 8));
            tick_chk("s5_held", 0, 0, 0, 0, 1, 3'(n % 8));
            pb_in = 1'b0;
            tick_chk("s5_release", 0, 1, 0, 0, 0, 3'(n % 8));
            tick_chk("s5_low", 0, 0, 0, 0, 0, 3'(n % 8));
            tick_chk("s5_low", 0, 0, 0, 0, 0, 3'(n % 8));
        end
        chk_int("s5_press_pulses", n_press, 9);
        chk_int("s5_release_pulses", n_rel, 9);

        // 6: single-cycle pulse
        pb_in = 1'b1;
        tick_chk("s6_press", 1, 0, 0, 0, 1, 3'd2);
        pb_in = 1'b0;
        tick_chk("s6_release", 0, 1, 0, 0, 0, 3'd2);
        tick_chk("s6_idle", 0, 0, 0, 0, 0, 3'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
